// File: rtl/pipe_adder.sv
// Pipelined ripple adder: one CHUNK-bit slice per stage, valid/ready flow control.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned MSB    = WIDTH - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // The whole pipeline moves as one; a full last stage blocks only if downstream stalls.
    assign in_ready = !valid_q[STAGES-1] || out_ready;

    always_comb begin
        logic [WIDTH-1:0] pa, pb, ps;
        logic             pc;
        logic [CHUNK:0]   part;
        int unsigned      j;
        pa      = '0;
        pb      = '0;
        ps      = '0;
        pc      = 1'b0;
        part    = '0;
        j       = 0;
        valid_d = '0;
        carry_d = '0;
        a_d     = '{default: '0};
        b_d     = '{default: '0};
        sum_d   = '{default: '0};
        for (int unsigned k = 0; k < STAGES; k++) begin
            j = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                pa         = a;
                pb         = b;
                pc         = cin;
                ps         = '0;
                valid_d[k] = in_valid;
            end else begin
                pa         = a_q[j];
                pb         = b_q[j];
                pc         = carry_q[j];
                ps         = sum_q[j];
                valid_d[k] = valid_q[j];
            end
            part = {1'b0, pa[k*CHUNK +: CHUNK]} + {1'b0, pb[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, pc};
            a_d[k]                    = pa;
            b_d[k]                    = pb;
            sum_d[k]                  = ps;
            sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            carry_d[k]                = part[CHUNK];
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Evaluated as the item enters the last stage, so it is registered with the sum.
    assign ovf_d = (a_d[STAGES-1][MSB] == b_d[STAGES-1][MSB])
                && (sum_d[STAGES-1][MSB] != a_d[STAGES-1][MSB]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_ready) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            sum_q   <= '{default: '0};
        end else if (in_ready) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Randomized/directed bench for pipe_adder (WIDTH=32, CHUNK=8) with a queue-based model.
module tb_pipe_adder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int          LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid, out_ready;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               acc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_lat  = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          head_seen = 1'b0;
    bit          hold_prev = 1'b0;
    logic [32:0] held;

    pipe_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .cout     (cout),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: sampled mid-cycle, ahead of the edge where transfers happen.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            head_seen = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({cout, sum}), 64'(held));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (chk_lat) check("latency", 64'(cyc - q[0].acc + 1), 64'(LAT));
                    end
                    if (out_ready) begin
                        check("sum", 64'(sum), 64'(q[0].s));
                        check("cout", 64'(cout), 64'(q[0].c));
`ifdef PIPE_ADDER_OVF_EN
                        check("ovf", 64'(ovf), 64'(q[0].o));
`endif
                        void'(q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            hold_prev = out_valid && !out_ready;
            held      = {cout, sum};
            if (in_valid && in_ready) begin
                exp_t e;
                logic [32:0] full;
                full  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                e.s   = full[31:0];
                e.c   = full[32];
                e.o   = (a[31] == b[31]) && (full[31] != a[31]);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic offer(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            got = in_ready && rst_n;
            tick();
        end
        if (!got) check("offer_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && q.size() != 0; n++) tick();
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        tick();

        // Full carry ripple through every chunk
        chk_lat = 1'b1;
        offer(32'hFFFF_FFFF, 32'h0, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        check("ripple_early", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("ripple_valid", 64'(out_valid), 64'd1);
        check("ripple_sum", 64'(sum), 64'd0);
        check("ripple_cout", 64'(cout), 64'd1);
        tick();
        drain();

        // Back-to-back stream
        for (int i = 1; i <= 16; i++) offer(WIDTH'(i), WIDTH'(i), 1'b0);
        drain();

        // Output stall with a full pipeline
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) offer(WIDTH'(i), 32'd1000, 1'b0);
        in_valid = 1'b1;
        a        = 32'd77;
        b        = 32'd77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(sum), 64'd1001);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three items in flight; in_valid held high during reset
        for (int i = 5; i <= 7; i++) offer(WIDTH'(i), WIDTH'(i), 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'd9;
        b        = 32'd9;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(out_valid), 64'd0);
            if (i == 0) check("post_rst_sum", 64'(sum), 64'd0);
            tick();
        end
        chk_lat = 1'b1;
        offer(32'd123, 32'd456, 1'b1);
        drain();

`ifdef PIPE_ADDER_OVF_EN
        offer(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        offer(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
`endif

        // Random stream with random valid gaps and random backpressure
        chk_lat  = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] ra, rb;
            repeat ($urandom_range(0, 2)) tick();
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ~ra : $urandom;
            offer(ra, rb, 1'($urandom_range(0, 1)));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/sum width in bits; legal values are at least 2 and a multiple of CHUNK.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK, and legal values of STAGES are at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in.
REQ-008 The block SHALL have port in_valid, input, 1 bit; operands are offered when it is high.
REQ-009 The block SHALL have port in_ready, output, 1 bit; the block accepts operands when it is high.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the result (a+b+cin) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit, the carry out of the MSB.
REQ-012 The block SHALL have port out_valid, output, 1 bit; sum and cout are valid when it is high.
REQ-013 The block SHALL have port out_ready, input, 1 bit; the downstream accepts the result when it is high.
REQ-014 The block SHALL have port ovf, output, 1 bit, signed overflow; it exists only under PIPE_ADDER_OVF_EN.

Function
REQ-015 A transfer SHALL occur on an input when in_valid and in_ready are both high at a rising clk edge, and on the output when out_valid and out_ready are both high.
REQ-016 The datapath SHALL be STAGES register stages; stage k adds operand bits [k*CHUNK +: CHUNK] plus the registered carry of stage k-1, with cin used as the carry into stage 0.
REQ-017 Operand chunks not yet consumed and sum chunks already produced SHALL be delay-registered with the item, so that each item exits with a complete sum, cout and ovf.
REQ-018 Each stage SHALL hold a valid bit; in_ready is combinational and equals (!valid[STAGES-1] || out_ready).
REQ-019 When in_ready is high, all stages SHALL advance one position in the same cycle; stage 0 loads in_valid, and bubbles travel with the pipeline without collapsing.
REQ-020 When in_ready is low, every stage register SHALL hold its value, and sum, cout, out_valid and ovf SHALL stay stable until the output transfer.
REQ-021 out_valid SHALL equal valid[STAGES-1].
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; with STAGES=1 this is 1 cycle.
REQ-023 With out_ready held high, throughput SHALL be 1 result per cycle, in input order, with no loss or duplication.
REQ-024 A simultaneous output transfer and input transfer in the same cycle SHALL both complete.
REQ-025 Carry SHALL ripple across every chunk boundary, including the case where all chunks propagate.

Reset
REQ-026 While rst_n is low at a clk edge, all valid bits SHALL clear to 0, and all data, carry and ovf registers SHALL clear to 0.
REQ-027 After reset, out_valid, sum, cout and ovf SHALL read 0, and in_ready SHALL read 1.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight items; no result SHALL appear for them after rst_n rises.
REQ-029 in_valid SHALL be ignored in any cycle in which rst_n is low.

Configuration
REQ-030 With macro PIPE_ADDER_OVF_EN defined, the ovf port and its pipeline register SHALL exist, with ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) for the same item, registered alongside sum.
REQ-031 Without PIPE_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=32, CHUNK=8)
REQ-032 The bench SHALL cover this scenario: a=0xFFFFFFFF, b=0, cin=1 -> exactly 4 cycles later sum=0x00000000, cout=1 (full carry ripple).
REQ-033 The bench SHALL cover this scenario: back-to-back inputs 1+1, 2+2, ... 16+16 with out_ready=1 -> outputs 2, 4, ... 32 on consecutive cycles from cycle 4 onward.
REQ-034 The bench SHALL cover this scenario: out_ready=0 for 6 cycles with a full pipeline -> in_ready=0 and the output held stable; on release, all 4 items drain in order with no loss.
REQ-035 The bench SHALL cover this scenario: rst_n=0 for 1 cycle while 3 items are in flight -> out_valid=0 and no stale result afterward; the next input returns after 4 cycles.
REQ-036 The bench SHALL cover this scenario under PIPE_ADDER_OVF_EN: 0x7FFFFFFF+0x00000001 -> ovf=1, cout=0; and 0xFFFFFFFF+0x00000001 -> ovf=0, cout=1.
REQ-037 The bench SHALL cover this scenario: a random stream of 10k items with random valid/ready -> every sum/cout matches the reference model, in order.
